// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- 8N1 serial transmitter with a small byte FIFO.
//
// CPU-side writes push bytes into a FIFO. Each byte is sent on uart_out as one
// start bit (0), eight data bits LSB first and one stop bit (1). Every bit
// lasts CLKS_PER_BIT clock cycles. Queued bytes go out back to back.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   wr_en      in   push wr_data into the FIFO on this rising edge
//   wr_data    in   byte to transmit
//   fifo_full  out  FIFO holds FIFO_DEPTH entries
//   fifo_empty out  FIFO holds no entries
//   fifo_count out  current number of FIFO entries
//   overflow   out  one-cycle pulse after a write is dropped
//   tx_busy    out  a frame is in progress
//   uart_out   out  serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        tx_busy,
  output logic                        uart_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;

  // Transmit engine
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_wr_acc;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_head;

  // Fullness is taken from the registered flag, so a write while full is
  // dropped even when the engine pops in the same cycle.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_head   = r_mem[r_rd_ptr];

  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign tx_busy    = r_busy;
  assign uart_out   = r_tx;

  // Next occupancy: a simultaneous accepted write and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage array; contents need no reset because the pointers do.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, status flags and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH_C);
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= wr_en & r_full;
    end
  end

  // Transmit FSM next state, counters, shift register and line level.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = '0;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt = '0;
          if (r_bit != 3'd7) begin
            // bit 1 of the current shift value is the next bit on the line
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 3'd1;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end
      STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt = '0;
          if (!r_empty) begin
            // chain straight into the next frame with no idle gap
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transmit FSM registers; busy is registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Expected line waveforms, FIFO peaks and overflow counts are computed from
// the frame format and FIFO capacity; a simple mid-bit sampling receiver also
// decodes the recorded line.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;
  localparam int TAIL  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          tx_busy;
  logic          uart_out;

  int tests = 0;
  int fails = 0;

  bit         rec_on = 1'b0;
  bit         rec_line[$];
  bit         rec_busy[$];
  int         max_cnt;
  int         ovf_cycles;
  int         full_seen;
  int         nonempty_late;
  logic [7:0] dec_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_busy    (tx_busy),
    .uart_out   (uart_out)
  );

  always #5 clk = ~clk;

  // Recorder: one sample per clock, taken shortly after the rising edge.
  always @(posedge clk) begin
    #2;
    if (rec_on) begin
      if (rec_line.size() > 0 && !fifo_empty) nonempty_late++;
      rec_line.push_back(uart_out);
      rec_busy.push_back(tx_busy);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (overflow) ovf_cycles++;
      if (fifo_full) full_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check_i(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [FRAME-1:0] obs, input logic [FRAME-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal 8N1 waveform of one byte, sample k of the frame.
  function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
    logic [FRAME-1:0] w;
    for (int k = 0; k < FRAME; k++) begin
      int bi = k / CPB;
      if (bi == 0)      w[k] = 1'b0;
      else if (bi == 9) w[k] = 1'b1;
      else              w[k] = b[bi-1];
    end
    return w;
  endfunction

  function automatic logic [FRAME-1:0] line_slice(input int start);
    logic [FRAME-1:0] w;
    for (int k = 0; k < FRAME; k++) w[k] = rec_line[start + k];
    return w;
  endfunction

  function automatic logic [FRAME-1:0] busy_slice(input int start);
    logic [FRAME-1:0] w;
    for (int k = 0; k < FRAME; k++) w[k] = rec_busy[start + k];
    return w;
  endfunction

  // Mid-bit sampling receiver over the recorded line.
  task automatic decode();
    int i = 1;
    dec_q.delete();
    while (i < rec_line.size()) begin
      if (rec_line[i] == 1'b0 && rec_line[i-1] == 1'b1 && i + FRAME <= rec_line.size()) begin
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = rec_line[i + (k + 1) * CPB + CPB / 2];
        dec_q.push_back(b);
        i += 9 * CPB + CPB / 2;
      end else begin
        i++;
      end
    end
  endtask

  task automatic rec_clear();
    rec_line.delete();
    rec_busy.delete();
    max_cnt = 0;
    ovf_cycles = 0;
    full_seen = 0;
    nonempty_late = 0;
  endtask

  // Write d on consecutive clocks while idle, then check everything sent.
  task automatic run_frames(input string tag, input logic [7:0] d[$]);
    int n     = d.size();
    int n_acc = (n < DEPTH + 1) ? n : DEPTH + 1;
    int need  = 1 + n_acc * FRAME + TAIL;
    int exp_max = (n == 1) ? 1 : ((n - 1 < DEPTH) ? n - 1 : DEPTH);
    int exp_ovf = (n > DEPTH + 1) ? n - (DEPTH + 1) : 0;
    int tail_bad = 0;
    rec_clear();
    @(negedge clk);
    rec_on = 1'b1;
    foreach (d[i]) begin
      wr_en = 1'b1;
      wr_data = d[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    for (int g = 0; g < need + 20 && rec_line.size() < need; g++) @(negedge clk);
    rec_on = 1'b0;
    check_i($sformatf("%s_len", tag), int'(rec_line.size() >= need), 1);
    if (rec_line.size() >= need) begin
      check_i($sformatf("%s_latency", tag), int'({rec_line[0], rec_busy[0]}), 2);
      for (int f = 0; f < n_acc; f++) begin
        check_v($sformatf("%s_frame%0d", tag, f), line_slice(1 + f * FRAME), frame_wave(d[f]));
        check_v($sformatf("%s_busy%0d", tag, f), busy_slice(1 + f * FRAME), {FRAME{1'b1}});
      end
      for (int k = 1 + n_acc * FRAME; k < need; k++)
        if (rec_line[k] != 1'b1 || rec_busy[k] != 1'b0) tail_bad++;
      check_i($sformatf("%s_tail_idle", tag), tail_bad, 0);
      check_i($sformatf("%s_max_count", tag), max_cnt, exp_max);
      check_i($sformatf("%s_overflow_cycles", tag), ovf_cycles, exp_ovf);
      check_i($sformatf("%s_full_seen", tag), int'(full_seen > 0), int'(n >= DEPTH + 1));
      if (n == 1) check_i($sformatf("%s_empty_after_write", tag), nonempty_late, 0);
      decode();
      check_i($sformatf("%s_decoded_count", tag), dec_q.size(), n_acc);
      for (int f = 0; f < n_acc && f < dec_q.size(); f++)
        check_i($sformatf("%s_decoded%0d", tag, f), int'(dec_q[f]), int'(d[f]));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b55;
    int zeros;
    int busies;

    // Reset held for 4 clocks; outputs must show reset values.
    repeat (4) @(negedge clk);
    check_i("reset_uart_out", int'(uart_out), 1);
    check_i("reset_busy", int'(tx_busy), 0);
    check_i("reset_empty", int'(fifo_empty), 1);
    check_i("reset_full", int'(fifo_full), 0);
    check_i("reset_count", int'(fifo_count), 0);
    check_i("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    q = '{8'h55};
    run_frames("byte55", q);
    q = '{8'hC8};
    run_frames("byteC8", q);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frames("burst4", q);
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frames("overflow6", q);

    // Randomised bursts of 1..6 bytes.
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 6);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_frames($sformatf("rand%0d", r), q);
    end

    // Reset during data bit 3 of 0x55 with two bytes queued.
    b55 = 8'h55;
    rec_clear();
    @(negedge clk);
    rec_on = 1'b1;
    wr_en = 1'b1; wr_data = 8'h55; @(negedge clk);
    wr_data = 8'h3C; @(negedge clk);
    wr_data = 8'h96; @(negedge clk);
    wr_en = 1'b0;
    // sample index j is the line after edge start+j-1; bit 3 covers indices 41..50
    for (int g = 0; g < 200 && rec_line.size() < 46; g++) @(negedge clk);
    check_i("midrst_line_before", int'(uart_out), int'(b55[3]));
    check_i("midrst_count_before", int'(fifo_count), 2);
    rst = 1'b1;
    #1;
    rec_on = 1'b0;
    check_i("midrst_line", int'(uart_out), 1);
    check_i("midrst_count", int'(fifo_count), 0);
    check_i("midrst_busy", int'(tx_busy), 0);
    check_i("midrst_empty", int'(fifo_empty), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rec_clear();
    rec_on = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    rec_on = 1'b0;
    zeros = 0;
    busies = 0;
    foreach (rec_line[i]) begin
      if (rec_line[i] == 1'b0) zeros++;
      if (rec_busy[i] == 1'b1) busies++;
    end
    check_i("postrst_line_zeros", zeros, 0);
    check_i("postrst_busy_cycles", busies, 0);
    check_i("postrst_count", int'(fifo_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
